// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, instruction memory and the ID/EX stages.
// master = fetch_stage side, slave = surrounding pipeline / memory side.
interface fetch_stage_if;
   logic        Stall;
   logic [2:0]  PCSrc_ID;
   logic [25:0] JTarget_ID;
   logic [31:0] JRTarget_ID;
   logic        BrTaken_EX;
   logic [31:0] BrTarget_EX;
   logic [31:0] IMem_Data;
   logic [31:0] IMem_Addr;
   logic [31:0] PC;
   logic [31:0] IFID_Instruct;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_PC_31;
   logic        IFID_Valid;
   logic        Flush_IDEX;

   modport master (
      input  Stall, PCSrc_ID, JTarget_ID, JRTarget_ID,
      input  BrTaken_EX, BrTarget_EX, IMem_Data,
      output IMem_Addr, PC, IFID_Instruct, IFID_PCPlus4,
      output IFID_PC_31, IFID_Valid, Flush_IDEX
   );

   modport slave (
      output Stall, PCSrc_ID, JTarget_ID, JRTarget_ID,
      output BrTaken_EX, BrTarget_EX, IMem_Data,
      input  IMem_Addr, PC, IFID_Instruct, IFID_PCPlus4,
      input  IFID_PC_31, IFID_Valid, Flush_IDEX
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and the IF/ID register.
// Redirects load a bubble whose supervisor bit is forced high.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
   parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
   input  logic           clk,
   input  logic           reset,
   fetch_stage_if.master  bus
);

   localparam logic [2:0] SRC_J   = 3'd2;
   localparam logic [2:0] SRC_JR  = 3'd3;
   localparam logic [2:0] SRC_EXC = 3'd4;
   localparam logic [2:0] SRC_IRQ = 3'd5;

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pcp4;
   logic        r_pc31;
   logic        r_valid;

   logic [31:0] w_pcp4;
   logic [31:0] w_npc;
   logic        w_bubble;
   logic        w_hold;

   // Bit 31 is the mode bit; sequential fetch never changes it.
   assign w_pcp4 = {r_pc[31], r_pc[30:0] + 31'd4};

   always_comb begin
      w_npc    = w_pcp4;
      w_bubble = 1'b0;
      w_hold   = 1'b0;
      if (bus.BrTaken_EX) begin
         w_npc    = bus.BrTarget_EX;
         w_bubble = 1'b1;
      end else if (bus.Stall) begin
         w_npc  = r_pc;
         w_hold = 1'b1;
      end else begin
         unique case (bus.PCSrc_ID)
            SRC_IRQ: begin
               w_npc    = IRQ_VEC;
               w_bubble = 1'b1;
            end
            SRC_EXC: begin
               w_npc    = EXC_VEC;
               w_bubble = 1'b1;
            end
            SRC_J: begin
               w_npc    = {r_pcp4[31:28], bus.JTarget_ID, 2'b00};
               w_bubble = 1'b1;
            end
            SRC_JR: begin
               w_npc    = bus.JRTarget_ID;
               w_bubble = 1'b1;
            end
            default: begin
               w_npc    = w_pcp4;
               w_bubble = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc    <= RESET_PC;
         r_instr <= 32'd0;
         r_pcp4  <= RESET_PC;
         r_pc31  <= 1'b1;
         r_valid <= 1'b0;
      end else if (!w_hold) begin
         r_pc   <= w_npc;
         r_pcp4 <= w_pcp4;
         if (w_bubble) begin
            r_instr <= 32'd0;
            r_pc31  <= 1'b1;
            r_valid <= 1'b0;
         end else begin
            r_instr <= bus.IMem_Data;
            r_pc31  <= r_pc[31];
            r_valid <= 1'b1;
         end
      end
   end

   assign bus.IMem_Addr     = r_pc;
   assign bus.PC            = r_pc;
   assign bus.IFID_Instruct = r_instr;
   assign bus.IFID_PCPlus4  = r_pcp4;
   assign bus.IFID_PC_31    = r_pc31;
   assign bus.IFID_Valid    = r_valid;
   assign bus.Flush_IDEX    = bus.BrTaken_EX;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized stimulus for fetch_stage, checked against a
// transaction-level model of the fetch pipeline kept in the bench.
module tb_fetch_stage;

   logic clk;
   logic reset;
   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC (32'h8000_0000),
      .IRQ_VEC  (32'h8000_0004),
      .EXC_VEC  (32'h8000_0008)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   always_comb bus.IMem_Data = imem(bus.IMem_Addr);

   int n_vec;
   int n_err;

   // reference state: what ID should see and where IF points
   logic [31:0] m_pc, m_ins, m_p4;
   logic        m_p31, m_val;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("pc", bus.PC, m_pc);
      chk("imem_addr", bus.IMem_Addr, m_pc);
      chk("ifid_ins", bus.IFID_Instruct, m_ins);
      chk("ifid_p4", bus.IFID_PCPlus4, m_p4);
      chk("ifid_p31", {31'd0, bus.IFID_PC_31}, {31'd0, m_p31});
      chk("ifid_val", {31'd0, bus.IFID_Valid}, {31'd0, m_val});
   endtask

   task automatic model_reset();
      m_pc  = 32'h8000_0000;
      m_ins = 32'd0;
      m_p4  = 32'h8000_0000;
      m_p31 = 1'b1;
      m_val = 1'b0;
   endtask

   // One clock: drive after the falling edge, check after the rising edge.
   task automatic step(input bit st, input logic [2:0] src,
                       input logic [25:0] jt, input logic [31:0] jrt,
                       input bit br, input logic [31:0] bt);
      logic [31:0] seq, tgt;
      bit redirect, hold;
      bus.Stall       = st;
      bus.PCSrc_ID    = src;
      bus.JTarget_ID  = jt;
      bus.JRTarget_ID = jrt;
      bus.BrTaken_EX  = br;
      bus.BrTarget_EX = bt;
      #1;
      chk("flush", {31'd0, bus.Flush_IDEX}, {31'd0, br});
      seq = m_pc + 32'd4;
      seq[31] = m_pc[31];
      hold = 1'b0;
      redirect = 1'b1;
      if (br) tgt = bt;
      else if (st) begin
         hold = 1'b1;
         tgt = m_pc;
      end
      else if (src == 3'd5) tgt = 32'h8000_0004;
      else if (src == 3'd4) tgt = 32'h8000_0008;
      else if (src == 3'd2) tgt = {m_p4[31:28], jt, 2'b00};
      else if (src == 3'd3) tgt = jrt;
      else begin
         tgt = seq;
         redirect = 1'b0;
      end
      if (!hold) begin
         m_p4  = seq;
         m_ins = redirect ? 32'd0 : imem(m_pc);
         m_p31 = redirect ? 1'b1 : m_pc[31];
         m_val = !redirect;
         m_pc  = tgt;
      end
      @(posedge clk);
      #1;
      chk_all();
      @(negedge clk);
   endtask

   task automatic run();
      step(0, 3'd0, 26'd0, 32'd0, 0, 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      bus.Stall = 0;
      bus.PCSrc_ID = 3'd0;
      bus.JTarget_ID = 26'd0;
      bus.JRTarget_ID = 32'd0;
      bus.BrTaken_EX = 0;
      bus.BrTarget_EX = 32'd0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk_all();
      reset = 1'b1;

      run();
      chk("seq1", bus.PC, 32'h8000_0004);
      chk("first_valid", {31'd0, bus.IFID_Valid}, 32'd1);
      chk("first_ins", bus.IFID_Instruct, imem(32'h8000_0000));
      run();
      chk("seq2", bus.PC, 32'h8000_0008);

      // jr to set up IFID_PCPlus4 = 00400010 for the jump case
      step(0, 3'd3, 26'd0, 32'h0040_000C, 0, 32'd0);
      run();
      chk("p4_setup", bus.IFID_PCPlus4, 32'h0040_0010);
      step(0, 3'd2, 26'h010_0000, 32'd0, 0, 32'd0);
      chk("j_pc", bus.PC, 32'h0040_0000);
      chk("j_bubble", {31'd0, bus.IFID_Valid}, 32'd0);
      chk("j_p31", {31'd0, bus.IFID_PC_31}, 32'd1);

      step(0, 3'd3, 26'd0, 32'h8000_0040, 0, 32'd0);
      step(0, 3'd3, 26'd0, 32'h0000_1234, 0, 32'd0);
      chk("jr_pc", bus.PC, 32'h0000_1234);
      run();
      chk("user_p31", {31'd0, bus.IFID_PC_31}, 32'd0);

      step(1, 3'd5, 26'd0, 32'd0, 1, 32'h0000_0200);
      chk("br_pc", bus.PC, 32'h0000_0200);
      chk("br_bubble", {31'd0, bus.IFID_Valid}, 32'd0);

      step(1, 3'd4, 26'd0, 32'd0, 0, 32'd0);
      step(1, 3'd4, 26'd0, 32'd0, 0, 32'd0);
      chk("stall_pc", bus.PC, 32'h0000_0200);
      step(0, 3'd4, 26'd0, 32'd0, 0, 32'd0);
      chk("exc_pc", bus.PC, 32'h8000_0008);

      // PC wrap keeps bit 31
      step(0, 3'd3, 26'd0, 32'hFFFF_FFFC, 0, 32'd0);
      run();
      chk("wrap", bus.PC, 32'h8000_0000);

      step(0, 3'd3, 26'd0, 32'h0000_0300, 0, 32'd0);
      run();
      reset = 1'b0;
      #1;
      model_reset();
      chk_all();
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 400; i++) begin
         logic [31:0] bt, jrt;
         bt  = $urandom & 32'hFFFF_FFFC;
         jrt = $urandom & 32'hFFFF_FFFC;
         step(($urandom % 5) == 0,
              3'($urandom % 8),
              26'($urandom),
              jrt,
              ($urandom % 7) == 0,
              bt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus the IF/ID pipeline register, directly upstream of the ID-stage control decoder.
- Owns the PC and selects the next PC from the decoder's PCSrc code, EX-stage branch resolution and hazard stall.
- Presents Instruct, PC+4 and the supervisor bit (PC_31) to ID.
- Inserts NOP bubbles on redirects.

Parameters:
- RESET_PC, 32'h80000000, PC after reset (supervisor mode).
- IRQ_VEC, 32'h80000004, target for PCSrc=5 (interrupt).
- EXC_VEC, 32'h80000008, target for PCSrc=4 (illegal op).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- Stall  in  1  load-use hazard; hold PC and IF/ID.
- PCSrc_ID  in  3  decoder PCSrc for the instruction currently in ID.
- JTarget_ID  in  26  Instruct[25:0] of the ID instruction.
- JRTarget_ID  in  32  forwarded rs value for jr/jalr.
- BrTaken_EX  in  1  branch in EX resolved taken.
- BrTarget_EX  in  32  branch target from EX.
- IMem_Data  in  32  combinational instruction-memory read data.
- IMem_Addr  out  32  = PC.
- PC  out  32  current fetch PC.
- IFID_Instruct  out  32  instruction to ID.
- IFID_PCPlus4  out  32  PC+4 of the ID instruction.
- IFID_PC_31  out  1  supervisor bit for the ID instruction.
- IFID_Valid  out  1  0 = bubble.
- Flush_IDEX  out  1  combinational; squash the ID/EX register this cycle.

Behaviour:
- Reset (async, reset=0):
  - PC = RESET_PC.
  - IFID_Instruct = 0.
  - IFID_PCPlus4 = RESET_PC.
  - IFID_PC_31 = 1.
  - IFID_Valid = 0.
  - Reset mid-operation discards everything; first fetch is at RESET_PC on the first edge after release.
- PCPlus4 = {PC[31], PC[30:0]+4}; bit 31 is never changed by sequential increment.
- Next-PC priority, evaluated each edge (highest first):
  1. BrTaken_EX=1 -> BrTarget_EX. Overrides Stall and ID redirects, because the EX branch is older.
  2. Stall=1 -> PC held. Any PCSrc_ID redirect is ignored; the ID instruction replays.
  3. PCSrc_ID=5 -> IRQ_VEC.
  4. PCSrc_ID=4 -> EXC_VEC.
  5. PCSrc_ID=2 -> {IFID_PCPlus4[31:28], JTarget_ID, 2'b00}.
  6. PCSrc_ID=3 -> JRTarget_ID. All 32 bits are used, so jr may clear bit 31 to return to user mode.
  7. Otherwise (PCSrc_ID 0, 1, 6, 7) -> PCPlus4. Code 1 (branch) is resolved in EX, not here.
- IF/ID update on each edge:
  - Cases 1, 3, 4, 5, 6 load a bubble:
    - Instruct = 0, Valid = 0, PC_31 = 1.
    - PCPlus4 = PCPlus4 of the squashed fetch.
    - PC_31 = 1 on a bubble is mandatory so the decoder never raises an interrupt or exception on a bubble.
  - Case 2 holds all IF/ID fields.
  - Case 7 loads:
    - Instruct = IMem_Data.
    - PCPlus4 = PCPlus4.
    - PC_31 = PC[31].
    - Valid = 1.
- Flush_IDEX = BrTaken_EX. The ID instruction is squashed only when an EX branch is taken; Stall bubbles into ID/EX are handled by the hazard unit, not here.
- Latency:
  - Fetched instruction appears at IFID outputs 1 cycle after PC presents its address.
  - Jump/jr/exception/interrupt penalty = 1 bubble.
  - Taken branch penalty = 2 (IF/ID bubble plus Flush_IDEX).
- Simultaneous BrTaken_EX and PCSrc_ID=5: branch wins. The interrupt is re-presented by the decoder on a later non-bubble instruction while IRQ stays high.
- PC wrap: PC[30:0]=31'h7FFFFFFC increments to 0 with bit 31 preserved.

Test Plan:
- Reset release, no stalls -> PC goes 80000000, 80000004, 80000008; IFID_Instruct = IMem_Data of the previous PC; first IFID_Valid=1 one cycle after release.
- PCSrc_ID=2, IFID_PCPlus4=00400010, JTarget=0x0100000 -> next PC=00400000; IFID = bubble (Instruct=0, PC_31=1, Valid=0).
- PCSrc_ID=3, JRTarget=00001234 while PC=80000040 -> next PC=00001234; IFID_PC_31=0 on the following fetch.
- BrTaken_EX=1, BrTarget=00000200, with Stall=1 and PCSrc_ID=5 in the same cycle -> PC=00000200, Flush_IDEX=1, IFID bubble.
- Stall=1 for 2 cycles with PCSrc_ID=4 -> PC and IFID unchanged both cycles; after Stall drops, PCSrc_ID=4 -> PC=80000008.
- Assert reset mid-stream with PC=00000300 -> PC=80000000 and IFID_Valid=0 immediately, without waiting for a clock edge.
